score_bcd_converter: RTL and testbench

Sequential binary-to-BCD converter (shift-add-3 / double-dabble) that turns the game's binary score or counter into packed decimal digits. Sits directly upstream of the per-digit 4-bit-to-7-segment decoders on the DE1-SoC HEX displays. Each digit output drives one decoder. A per-digit blank mask lets the display wrapper suppress leading zeros.

---
 rtl/score_bcd_converter_if.sv | 24 ++
 rtl/score_bcd_converter.sv | 111 +++++++++++
 tb/tb_score_bcd_converter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/score_bcd_converter_if.sv
// Handshake and result bundle between a score source/display wrapper and the
// binary-to-BCD converter.
interface score_bcd_converter_if #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned NDIGITS = 6
);
  logic                   start;
  logic [WIDTH-1:0]       value;
  logic                   busy;
  logic                   done;
  logic [4*NDIGITS-1:0]   bcd;
  logic [NDIGITS-1:0]     blank;
  logic                   overflow;

  modport master (
    output start, value,
    input  busy, done, bcd, blank, overflow
  );

  modport slave (
    input  start, value,
    output busy, done, bcd, blank, overflow
  );
endinterface

// File: rtl/score_bcd_converter.sv
// Sequential shift-add-3 binary-to-BCD converter feeding the HEX digit decoders,
// with leading-zero blank mask and saturating overflow.
module score_bcd_converter #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned NDIGITS = 6
) (
  input logic                 clk,
  input logic                 reset,
  score_bcd_converter_if.slave bus
);
  localparam int unsigned BW = 4 * NDIGITS;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   bin;
  logic [BW-1:0]      work;
  logic [BW-1:0]      corr;
  logic               ovf_work;
  logic [CW-1:0]      cnt;

  logic               busy_q;
  logic               done_q;
  logic               ovf_q;
  logic [BW-1:0]      bcd_q;
  logic [NDIGITS-1:0] blank_q;
  logic [NDIGITS-1:0] blank_c;
  logic               seen;

  // Add-3 correction on every digit that would reach 10 or more after the shift
  always_comb begin
    corr = work;
    for (int i = 0; i < int'(NDIGITS); i++) begin
      if (work[4*i +: 4] >= 4'd5) begin
        corr[4*i +: 4] = work[4*i +: 4] + 4'd3;
      end
    end
  end

  // Digit i is blank when it and every digit above it are zero; digit 0 always shows
  always_comb begin
    seen    = 1'b0;
    blank_c = '0;
    for (int i = int'(NDIGITS) - 1; i >= 1; i--) begin
      seen       = seen | (work[4*i +: 4] != 4'd0);
      blank_c[i] = ~seen;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      bin      <= '0;
      work     <= '0;
      ovf_work <= 1'b0;
      cnt      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      bcd_q    <= '0;
      blank_q  <= ~NDIGITS'(1);
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bin      <= bus.value;
            work     <= '0;
            ovf_work <= 1'b0;
            cnt      <= CW'(WIDTH);
            busy_q   <= 1'b1;
            state    <= SHIFT;
          end else begin
            busy_q <= 1'b0;
          end
        end
        SHIFT: begin
          {work, bin} <= {corr[BW-2:0], bin, 1'b0};
          if (corr[BW-1]) begin
            ovf_work <= 1'b1;
          end
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          // busy stays high through the done cycle and drops in IDLE unless restarted
          done_q <= 1'b1;
          ovf_q  <= ovf_work;
          state  <= IDLE;
          if (ovf_work) begin
            bcd_q   <= {NDIGITS{4'h9}};
            blank_q <= '0;
          end else begin
            bcd_q   <= work;
            blank_q <= blank_c;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bcd      = bcd_q;
  assign bus.blank    = blank_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_score_bcd_converter.sv
// Bench for score_bcd_converter: a 6-digit and a 4-digit instance share one
// stimulus stream and are compared every cycle against a decimal-arithmetic model.
module tb_score_bcd_converter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] value = '0;
  logic        chk_en = 1'b0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  score_bcd_converter_if #(.WIDTH(16), .NDIGITS(6)) bus6 ();
  score_bcd_converter_if #(.WIDTH(16), .NDIGITS(4)) bus4 ();

  assign bus6.start = start;
  assign bus6.value = value;
  assign bus4.start = start;
  assign bus4.value = value;

  score_bcd_converter #(.WIDTH(16), .NDIGITS(6)) dut6 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus6.slave)
  );

  score_bcd_converter #(.WIDTH(16), .NDIGITS(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal digits by division; blank[i] is simply value < 10^i
  function automatic void conv(input int unsigned v, input int unsigned n,
                               output logic [23:0] b, output logic [5:0] bl,
                               output logic o);
    int unsigned lim;
    int unsigned p;
    lim = 1;
    for (int i = 0; i < int'(n); i++) lim = lim * 10;
    b  = '0;
    bl = '0;
    if (v >= lim) begin
      o = 1'b1;
      for (int i = 0; i < int'(n); i++) b[4*i +: 4] = 4'h9;
    end else begin
      o = 1'b0;
      p = 1;
      for (int i = 0; i < int'(n); i++) begin
        b[4*i +: 4] = 4'((v / p) % 10);
        if (i > 0) bl[i] = (v < p);
        p = p * 10;
      end
    end
  endfunction

  // Timing model: done arrives 17 edges after the accepting edge
  logic        m_act, m_busy, m_done, m_ovf6, m_ovf4;
  int          m_age;
  logic [15:0] m_val;
  logic [23:0] m_bcd6, t_b6, t_b4;
  logic [5:0]  m_blank6, t_bl6, t_bl4;
  logic [15:0] m_bcd4;
  logic [3:0]  m_blank4;
  logic        t_o6, t_o4;

  always @(posedge clk) begin
    if (reset) begin
      m_act <= 1'b0; m_age <= 0; m_busy <= 1'b0; m_done <= 1'b0;
      m_bcd6 <= '0; m_blank6 <= 6'b111110; m_ovf6 <= 1'b0;
      m_bcd4 <= '0; m_blank4 <= 4'b1110;   m_ovf4 <= 1'b0;
    end else begin
      m_done <= 1'b0;
      m_busy <= m_act | start;
      if (m_act) begin
        m_age <= m_age + 1;
        if (m_age == 16) begin
          conv(32'(m_val), 6, t_b6, t_bl6, t_o6);
          conv(32'(m_val), 4, t_b4, t_bl4, t_o4);
          m_act <= 1'b0; m_done <= 1'b1;
          m_bcd6 <= t_b6; m_blank6 <= t_bl6; m_ovf6 <= t_o6;
          m_bcd4 <= t_b4[15:0]; m_blank4 <= t_bl4[3:0]; m_ovf4 <= t_o4;
        end
      end else if (start) begin
        m_act <= 1'b1; m_age <= 0; m_val <= value;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy6",  32'(bus6.busy),     32'(m_busy));
      chk("done6",  32'(bus6.done),     32'(m_done));
      chk("bcd6",   32'(bus6.bcd),      32'(m_bcd6));
      chk("blank6", 32'(bus6.blank),    32'(m_blank6));
      chk("ovf6",   32'(bus6.overflow), 32'(m_ovf6));
      chk("busy4",  32'(bus4.busy),     32'(m_busy));
      chk("done4",  32'(bus4.done),     32'(m_done));
      chk("bcd4",   32'(bus4.bcd),      32'(m_bcd4));
      chk("blank4", 32'(bus4.blank),    32'(m_blank4));
      chk("ovf4",   32'(bus4.overflow), 32'(m_ovf4));
    end
  end

  // Called at a negedge; returns at the negedge where done is seen (or on timeout)
  task automatic run_conv(input logic [15:0] v, output int lat);
    int n;
    start = 1'b1;
    value = v;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!bus6.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    lat = n - 1;
  endtask

  logic [15:0] bvals [4] = '{16'd9999, 16'd10000, 16'd0, 16'hFFFF};

  initial begin
    int lat;
    int dones;
    int r;
    int sel;

    // Reset held two cycles with start high
    reset = 1'b1; start = 1'b1; value = 16'd1234;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",  32'(bus6.busy),     32'd0);
    chk("rst_done",  32'(bus6.done),     32'd0);
    chk("rst_bcd",   32'(bus6.bcd),      32'h000000);
    chk("rst_blank", 32'(bus6.blank),    32'b111110);
    chk("rst_ovf",   32'(bus6.overflow), 32'd0);
    chk("rst_blank4", 32'(bus4.blank),   32'b1110);
    chk_en = 1'b1;
    reset = 1'b0; start = 1'b0;

    // 12345 with exact latency and single-cycle done
    run_conv(16'd12345, lat);
    chk("lat_12345",   32'(lat),           32'd17);
    chk("bcd_12345",   32'(bus6.bcd),      32'h012345);
    chk("blank_12345", 32'(bus6.blank),    32'b100000);
    chk("ovf_12345",   32'(bus6.overflow), 32'd0);
    @(negedge clk);
    chk("done_width",  32'(bus6.done),     32'd0);

    // Back-to-back: second start during the done cycle
    run_conv(16'd0, lat);
    chk("bcd_0",       32'(bus6.bcd),   32'h000000);
    chk("blank_0",     32'(bus6.blank), 32'b111110);
    run_conv(16'd65535, lat);
    chk("lat_b2b",     32'(lat),        32'd17);
    chk("bcd_65535",   32'(bus6.bcd),   32'h065535);
    chk("blank_65535", 32'(bus6.blank), 32'b100000);

    // Start while busy ignored, value changes mid-flight ignored
    @(negedge clk);
    start = 1'b1; value = 16'd500;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; value = 16'd999;
    @(negedge clk);
    start = 1'b0; value = 16'd4242;
    dones = 0;
    for (int i = 0; i < 45; i++) begin
      if (bus6.done) begin
        dones++;
        chk("bcd_500",   32'(bus6.bcd),   32'h000500);
        chk("blank_500", 32'(bus6.blank), 32'b111000);
      end
      @(negedge clk);
    end
    chk("dones_500", 32'(dones), 32'd1);

    // Overflow on the 4-digit instance
    run_conv(16'd10000, lat);
    chk("ovf4_10000",   32'(bus4.overflow), 32'd1);
    chk("bcd4_10000",   32'(bus4.bcd),      32'h9999);
    chk("blank4_10000", 32'(bus4.blank),    32'b0000);
    chk("bcd6_10000",   32'(bus6.bcd),      32'h010000);
    run_conv(16'd9999, lat);
    chk("ovf4_9999",    32'(bus4.overflow), 32'd0);
    chk("bcd4_9999",    32'(bus4.bcd),      32'h9999);
    chk("blank4_9999",  32'(bus4.blank),    32'b0000);

    // Reset on the 8th SHIFT clock aborts the conversion
    @(negedge clk);
    start = 1'b1; value = 16'd4321;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy",  32'(bus6.busy),  32'd0);
    chk("abort_bcd",   32'(bus6.bcd),   32'h000000);
    chk("abort_blank", 32'(bus6.blank), 32'b111110);
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus6.done) dones++;
      @(negedge clk);
    end
    chk("abort_nodone", 32'(dones), 32'd0);
    run_conv(16'd77, lat);
    chk("bcd_77",   32'(bus6.bcd),   32'h000077);
    chk("blank_77", 32'(bus6.blank), 32'b111100);

    // Random traffic, checked every cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      r = int'($urandom % 8);
      start = (r < 3);
      sel = int'($urandom % 4);
      if (sel == 0)      value = 16'($urandom_range(0, 99));
      else if (sel == 1) value = bvals[$urandom % 4];
      else               value = 16'($urandom);
      reset = ($urandom % 500 == 0);
    end
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    repeat (25) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
